// File: rtl/param_acc_alu.sv
`default_nettype none
// ============================================================================
//  Module   : param_acc_alu
//  Brief    : Parametrised accumulator ALU with an OFF/READY/RUN/ERROR
//             controller, multi-cycle shift-add multiplier and sticky
//             overflow error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module param_acc_alu #(
   parameter int WIDTH  = 8,
   parameter int SAT_EN = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic [1:0]       in_sel,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   input  logic             clr_err,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic             error,
   output logic [1:0]       state
);

   // Operation encodings
   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_NOT  = 3'd2;
   localparam logic [2:0] OP_XOR  = 3'd3;
   localparam logic [2:0] OP_ADD  = 3'd4;
   localparam logic [2:0] OP_SUB  = 3'd5;
   localparam logic [2:0] OP_MUL  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   // Accumulator source selection at accept
   localparam logic [1:0] SEL_LOAD  = 2'b01;
   localparam logic [1:0] SEL_CLEAR = 2'b10;

   // Multiplier step counter width (one step per multiplier bit)
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_READY = 2'b01,
      ST_RUN   = 2'b10,
      ST_ERROR = 2'b11
   } state_t;

   state_t cur_state;
   state_t nxt_state;

   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   opnd;
   logic [2:0]         op_lat;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] prod;

   logic               accept;
   logic               finish;
   logic [2*WIDTH-1:0] part;
   logic [2*WIDTH-1:0] prod_sum;
   logic [WIDTH:0]     add_full;
   logic [WIDTH-1:0]   alu_val;
   logic               alu_ovf;

   // New operation is taken only when powered, idle and requested
   assign accept = (cur_state == ST_READY) && en && start;

   // Single-cycle ops finish on the first RUN edge; MUL after WIDTH steps
   assign finish = (cur_state == ST_RUN) &&
                   ((op_lat != OP_MUL) || (cnt == LAST_STEP));

   // Shift-add partial product for the current multiplier bit
   always_comb begin
      part     = '0;
      if (opnd[cnt]) begin
         part = {{WIDTH{1'b0}}, acc} << cnt;
      end
      prod_sum = prod + part;
      add_full = {1'b0, acc} + {1'b0, opnd};
   end

   // Write-back value and overflow for the latched operation
   always_comb begin
      alu_val = acc;
      alu_ovf = 1'b0;
      case (op_lat)
         OP_AND:  alu_val = acc & opnd;
         OP_OR:   alu_val = acc | opnd;
         OP_NOT:  alu_val = ~acc;
         OP_XOR:  alu_val = acc ^ opnd;
         OP_ADD: begin
            alu_ovf = add_full[WIDTH];
            alu_val = add_full[WIDTH-1:0];
            if ((SAT_EN != 0) && alu_ovf) begin
               alu_val = {WIDTH{1'b1}};
            end
         end
         OP_SUB: begin
            alu_ovf = (acc < opnd);
            alu_val = acc - opnd;
            if ((SAT_EN != 0) && alu_ovf) begin
               alu_val = '0;
            end
         end
         OP_MUL: begin
            alu_ovf = |prod_sum[2*WIDTH-1:WIDTH];
            alu_val = prod_sum[WIDTH-1:0];
            if ((SAT_EN != 0) && alu_ovf) begin
               alu_val = {WIDTH{1'b1}};
            end
         end
         OP_PASS: alu_val = acc;
         default: alu_val = acc;
      endcase
   end

   // Controller state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= ST_OFF;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Controller next-state; en/start are only looked at in OFF/READY
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         ST_OFF: begin
            if (en) nxt_state = ST_READY;
         end
         ST_READY: begin
            if (!en)        nxt_state = ST_OFF;
            else if (start) nxt_state = ST_RUN;
         end
         ST_RUN: begin
            if (finish) nxt_state = alu_ovf ? ST_ERROR : ST_READY;
         end
         ST_ERROR: begin
            if (clr_err) nxt_state = ST_READY;
         end
         default: nxt_state = ST_OFF;
      endcase
   end

   // Datapath: operand capture, multiplier stepping, write-back and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         opnd   <= '0;
         op_lat <= OP_AND;
         cnt    <= '0;
         prod   <= '0;
         done   <= 1'b0;
         ovf    <= 1'b0;
         error  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            opnd   <= num2;
            op_lat <= op;
            cnt    <= '0;
            prod   <= '0;
            if (in_sel == SEL_LOAD) begin
               acc <= num1;
            end else if (in_sel == SEL_CLEAR) begin
               acc <= '0;
            end
         end
         if (cur_state == ST_RUN) begin
            if (finish) begin
               acc  <= alu_val;
               done <= 1'b1;
               ovf  <= alu_ovf;
               if (alu_ovf) error <= 1'b1;
            end else begin
               prod <= prod_sum;
               cnt  <= cnt + CW'(1);
            end
         end
         if ((cur_state == ST_ERROR) && clr_err) begin
            error <= 1'b0;
         end
      end
   end

   assign result = acc;
   assign busy   = (cur_state == ST_RUN);
   assign state  = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_param_acc_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_acc_alu
//  Brief    : Self-checking bench for param_acc_alu (WIDTH=8, SAT_EN=0).
//             Vector table plus hand-written error/reset sequences; results
//             are checked through a done-driven scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_acc_alu;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       start;
   logic [1:0] in_sel;
   logic [2:0] op;
   logic [7:0] num1;
   logic [7:0] num2;
   logic       clr_err;
   logic [7:0] result;
   logic       busy;
   logic       done;
   logic       ovf;
   logic       error;
   logic [1:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [1:0] sel;
      logic [2:0] op;
      logic [7:0] n1;
      logic [7:0] n2;
      logic [7:0] res;
      logic       ovf;
   } vec_t;

   vec_t       vecs[15];
   logic [8:0] exp_q[$];

   param_acc_alu #(.WIDTH(8), .SAT_EN(0)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .in_sel(in_sel),
      .op(op), .num1(num1), .num2(num2), .clr_err(clr_err),
      .result(result), .busy(busy), .done(done), .ovf(ovf),
      .error(error), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Scoreboard: every done pulse must match the oldest expectation
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("done_result", {24'd0, result}, {24'd0, e[8:1]});
            check("done_ovf", {31'd0, ovf}, {31'd0, e[0]});
         end
      end
   end

   task automatic wait_ready();
      int g = 0;
      @(negedge clk);
      while (state !== 2'b01 && g < 20) begin
         g++;
         @(negedge clk);
      end
      check("wait_ready", {30'd0, state}, 32'd1);
   endtask

   task automatic do_op(input vec_t v, input bit poke);
      int bcnt = 0;
      int guard = 0;
      int exp_busy;
      exp_busy = (v.op == 3'd6) ? 8 : 1;
      wait_ready();
      in_sel = v.sel; op = v.op; num1 = v.n1; num2 = v.n2; start = 1'b1;
      exp_q.push_back({v.res, v.ovf});
      @(posedge clk);
      #1;
      start  = 1'b0;
      num1   = 8'($urandom);
      num2   = 8'($urandom);
      op     = 3'($urandom);
      in_sel = 2'($urandom);
      @(negedge clk);
      while (busy === 1'b1 && guard < 40) begin
         bcnt++;
         guard++;
         start = (poke && bcnt == 3);
         @(negedge clk);
      end
      start = 1'b0;
      check("busy_cycles", bcnt, exp_busy);
      check("state_after_op", {30'd0, state}, v.ovf ? 32'd3 : 32'd1);
      check("error_after_op", {31'd0, error}, {31'd0, v.ovf});
   endtask

   // ERROR holds against start; clr_err returns to READY and drops start
   task automatic err_seq();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_hold_state", {30'd0, state}, 32'd3);
      check("err_busy_low", {31'd0, busy}, 32'd0);
      clr_err = 1'b1;
      start   = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      start   = 1'b0;
      check("clr_state", {30'd0, state}, 32'd1);
      check("clr_error", {31'd0, error}, 32'd0);
      @(negedge clk);
      check("clr_start_dropped", {30'd0, state}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{2'b01, 3'd4, 8'h12, 8'h34, 8'h46, 1'b0};
      vecs[1]  = '{2'b01, 3'd4, 8'hF0, 8'h20, 8'h10, 1'b1};
      vecs[2]  = '{2'b01, 3'd6, 8'h0F, 8'h11, 8'hFF, 1'b0};
      vecs[3]  = '{2'b01, 3'd6, 8'h10, 8'h10, 8'h00, 1'b1};
      vecs[4]  = '{2'b01, 3'd5, 8'h05, 8'h03, 8'h02, 1'b0};
      vecs[5]  = '{2'b00, 3'd5, 8'h77, 8'h03, 8'hFF, 1'b1};
      vecs[6]  = '{2'b01, 3'd0, 8'hA5, 8'h0F, 8'h05, 1'b0};
      vecs[7]  = '{2'b01, 3'd1, 8'hA5, 8'h0F, 8'hAF, 1'b0};
      vecs[8]  = '{2'b01, 3'd3, 8'hA5, 8'h0F, 8'hAA, 1'b0};
      vecs[9]  = '{2'b01, 3'd2, 8'hA5, 8'h0F, 8'h5A, 1'b0};
      vecs[10] = '{2'b10, 3'd4, 8'h99, 8'h07, 8'h07, 1'b0};
      vecs[11] = '{2'b00, 3'd7, 8'h99, 8'h55, 8'h07, 1'b0};
      vecs[12] = '{2'b11, 3'd4, 8'h99, 8'h01, 8'h08, 1'b0};
      vecs[13] = '{2'b01, 3'd6, 8'hFF, 8'hFF, 8'h01, 1'b1};
      vecs[14] = '{2'b01, 3'd6, 8'h0D, 8'h0B, 8'h8F, 1'b0};

      rst = 1'b1; en = 1'b0; start = 1'b0; in_sel = 2'b00; op = 3'd0;
      num1 = 8'h00; num2 = 8'h00; clr_err = 1'b0;
      #12;
      check("rst_state", {30'd0, state}, 32'd0);
      check("rst_result", {24'd0, result}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b1;
      repeat (2) @(negedge clk);
      check("off_ignores_start", {30'd0, state}, 32'd0);
      start = 1'b0;
      en    = 1'b1;

      for (int i = 0; i < 15; i++) begin
         do_op(vecs[i], i == 2);
         if (vecs[i].ovf) err_seq();
      end

      // Reset during the 4th RUN cycle of a multiply: immediate, no done
      wait_ready();
      in_sel = 2'b01; op = 3'd6; num1 = 8'h03; num2 = 8'h05; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_state", {30'd0, state}, 32'd0);
      check("abort_result", {24'd0, result}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("ready_after_abort", {30'd0, state}, 32'd1);
      en = 1'b0;
      @(negedge clk);
      check("en_low_off", {30'd0, state}, 32'd0);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
